// File: rtl/stall_hold_ram.sv
// stall_hold_ram: synchronous RAM responder with stall-aware read pipeline
// Ports:
//   clk, rst                        clock, async active-high reset
//   global_stall                    freezes read pipeline, drops functional writes
//   ren, raddr -> rdata, rvalid     read request and READ_LAT-cycle response
//   wen, waddr, wdata               functional write port
//   debug_addr -> debug_data        combinational debug read
//   debug_write_en/_addr/_data      debug write, ignores stall and reset
module stall_hold_ram #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AWIDTH   = 5,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              global_stall,
    input  logic              ren,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    input  logic              wen,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [AWIDTH-1:0] debug_addr,
    output logic [WIDTH-1:0]  debug_data,
    input  logic              debug_write_en,
    input  logic [AWIDTH-1:0] debug_write_addr,
    input  logic [WIDTH-1:0]  debug_write_data
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [READ_LAT-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]    dat_q [READ_LAT];
    logic [WIDTH-1:0]    dat_d [READ_LAT];

    // Out-of-range addresses alias modulo DEPTH.
    function automatic logic [IW-1:0] idx(input logic [AWIDTH-1:0] a);
        return IW'(32'(a) % 32'(DEPTH));
    endfunction

    // No reset on the array; the debug write comes last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (wen && !global_stall) mem_q[idx(waddr)] <= wdata;
        if (debug_write_en) mem_q[idx(debug_write_addr)] <= debug_write_data;
    end

    // Data only advances alongside a valid, so bubbles leave rdata untouched.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (!global_stall) begin
            vld_d[0] = ren;
            dat_d[0] = ren ? mem_q[idx(raddr)] : dat_q[0];
            for (int k = 1; k < READ_LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign rdata      = dat_q[READ_LAT-1];
    assign rvalid     = vld_q[READ_LAT-1];
    assign debug_data = mem_q[idx(debug_addr)];
endmodule

// File: tb/tb_stall_hold_ram.sv
// tb_stall_hold_ram: scoreboard bench for stall_hold_ram at READ_LAT 1, 2 and 3
module tb_stall_hold_ram;
    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        global_stall = 0;
    logic [2:0]  ren = '0;
    logic [4:0]  raddr = '0;
    logic        wen = 0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  debug_addr = '0;
    logic        dwe = 0;
    logic [4:0]  dwa = '0;
    logic [31:0] dwd = '0;
    logic [2:0]  rv;
    logic [31:0] rd [3];
    logic [31:0] dd [3];
    logic        stall_e = 0;
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    exp_t        q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        stall_e <= global_stall;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        stall_hold_ram #(.WIDTH(32), .DEPTH(16), .AWIDTH(5), .READ_LAT(g + 1)) u_dut (
            .clk(clk), .rst(rst), .global_stall(global_stall),
            .ren(ren[g]), .raddr(raddr), .rdata(rd[g]), .rvalid(rv[g]),
            .wen(wen), .waddr(waddr), .wdata(wdata),
            .debug_addr(debug_addr), .debug_data(dd[g]),
            .debug_write_en(dwe), .debug_write_addr(dwa), .debug_write_data(dwd)
        );
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pops one expectation per completed read; a held rvalid across a stall is not a new completion.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && !stall_e)
            for (int i = 0; i < 3; i++)
                if (rv[i]) begin
                    if (q[i].size() == 0) chk($sformatf("unexpected_rvalid%0d", i), 32'(q[i].size()), 1);
                    else begin
                        e = q[i].pop_front();
                        chk($sformatf("rdata%0d", i), rd[i], e.d);
                        chk($sformatf("rcycle%0d", i), 32'(cyc), 32'(e.c));
                    end
                end
    end

    initial begin
        dwe = 1; dwa = 1; dwd = 10;
        tick;
        dwa = 2; dwd = 33;
        tick;
        dwe = 0;
        rst = 0;
        debug_addr = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_rvalid%0d", i), 32'(rv[i]), 0);
            chk($sformatf("rst_rdata%0d", i), rd[i], 0);
        end
        chk("dbg_write_in_rst", dd[0], 10);
        // single-cycle read then bubble
        ren[0] = 1; raddr = 1; q[0].push_back('{10, cyc + 1});
        tick;
        ren[0] = 0;
        tick;
        chk("bubble_rvalid", 32'(rv[0]), 0);
        chk("bubble_rdata", rd[0], 10);
        // stall holds outputs and stretches the 3-cycle read by 5
        ren = 3'b101; raddr = 1;
        q[0].push_back('{10, cyc + 1});
        q[2].push_back('{10, cyc + 1 + 2 + 5});
        tick;
        global_stall = 1; ren = 3'b111; raddr = 1;
        for (int s = 0; s < 5; s++) begin
            tick;
            chk("stall_hold_rvalid", 32'(rv[0]), 1);
            chk("stall_hold_rdata", rd[0], 10);
            chk("stall_lat3_rvalid", 32'(rv[2]), 0);
        end
        global_stall = 0; ren = '0;
        tick;
        chk("resume_lat3_early", 32'(rv[2]), 0);
        tick;
        tick;
        chk("lat3_bubble_rvalid", 32'(rv[2]), 0);
        chk("lat3_bubble_rdata", rd[2], 10);
        // writes are dropped during a stall
        global_stall = 1; wen = 1; waddr = 2; wdata = 20; debug_addr = 2;
        tick;
        global_stall = 0; wen = 0;
        #1;
        chk("stalled_write_dropped", dd[0], 33);
        wen = 1;
        tick;
        wen = 0;
        chk("write_unstalled", dd[0], 20);
        // debug write wins a collision, read-before-write
        wen = 1; waddr = 3; wdata = 5; dwe = 1; dwa = 3; dwd = 7; debug_addr = 3;
        tick;
        wen = 0; dwe = 0;
        chk("debug_wins", dd[0], 7);
        ren[0] = 1; raddr = 3; wen = 1; waddr = 3; wdata = 9;
        q[0].push_back('{7, cyc + 1});
        tick;
        ren[0] = 0; wen = 0;
        chk("write_after_read", dd[0], 9);
        debug_addr = 19;
        #1;
        chk("addr_alias", dd[1], 9);
        tick;
        // reset discards an in-flight 2-cycle read
        ren[1] = 1; raddr = 1;
        tick;
        ren[1] = 0;
        #2 rst = 1;
        #1;
        chk("rst_async_rvalid", 32'(rv[1]), 0);
        chk("rst_async_rdata", rd[1], 0);
        tick;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("no_stale_rvalid", 32'(rv[1]), 0);
        end
        debug_addr = 1;
        #1;
        chk("mem_kept1", dd[2], 10);
        debug_addr = 3;
        #1;
        chk("mem_kept3", dd[2], 9);
        tick;
        tick;
        for (int i = 0; i < 3; i++) chk($sformatf("queue_drained%0d", i), 32'(q[i].size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
